serializer: RTL

Parallel-to-serial transmitter that feeds the receive-side deserializer of the message/key path. It accepts a DATA_SIZE-bit word through a valid/ready handshake and shifts it out MSB-first, one bit per enabled clock. A load-flag qualifier marks each valid bit. A done pulse reports frame completion to the upstream controller.

---
 rtl/serializer_pkg.sv | 23 ++
 rtl/serializer_if.sv | 37 +++
 rtl/serializer.sv | 103 ++++++++++
 3 files changed

// File: rtl/serializer_pkg.sv
// Shared definitions for the serializer / deserializer message-key path.
// Holds the frame FSM state encoding, the default word width and the
// bit-counter width rule both ends of the link must agree on.
package serializer_pkg;

  // Frame FSM encoding. 2'd3 is unused and recovers to ST_IDLE.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  // Default parallel word width (bits per frame), must be >= 2.
  localparam int DATA_SIZE_DEFAULT = 8;

  // The bit counter must be able to hold DATA_SIZE itself, not just DATA_SIZE-1.
  function automatic int cnt_width(input int n);
    return $clog2(n) + 1;
  endfunction

  localparam int CNT_W_DEFAULT = cnt_width(DATA_SIZE_DEFAULT);

endpackage : serializer_pkg

// File: rtl/serializer_if.sv
// Handshake and serial-link bundle of the serializer.
//   iEn          : shift enable (upstream -> serializer)
//   iValid/iData : parallel word offer (upstream -> serializer)
//   oReady       : serializer can accept a word
//   oSerial_out  : serial bit, MSB first
//   oLoad_flag   : oSerial_out carries a valid frame bit
//   oBit_counter : bits emitted in the current frame
//   oBusy/oDone  : frame in progress / one-cycle frame-complete pulse
// master = upstream controller side, slave = serializer side.
interface serializer_if
  import serializer_pkg::*;
#(
  parameter int DATA_SIZE = DATA_SIZE_DEFAULT
);
  localparam int CW = cnt_width(DATA_SIZE);

  logic                 iEn;
  logic                 iValid;
  logic [DATA_SIZE-1:0] iData;
  logic                 oReady;
  logic                 oSerial_out;
  logic                 oLoad_flag;
  logic [CW-1:0]        oBit_counter;
  logic                 oBusy;
  logic                 oDone;

  modport master (
    output iEn, iValid, iData,
    input  oReady, oSerial_out, oLoad_flag, oBit_counter, oBusy, oDone
  );

  modport slave (
    input  iEn, iValid, iData,
    output oReady, oSerial_out, oLoad_flag, oBit_counter, oBusy, oDone
  );

endinterface : serializer_if

// File: rtl/serializer.sv
// Parallel-to-serial transmitter. Captures a DATA_SIZE-bit word on a
// valid/ready handshake while idle and emits it MSB first, one bit per
// enabled clock, qualified by oLoad_flag. oDone pulses for one cycle after
// the last bit. iEn=0 during a frame inserts gap cycles without losing data.
// Ports:
//   iClk : clock, rising edge
//   iRst : asynchronous active-low reset
//   bus  : serializer_if slave modport (handshake, serial link, status)
module serializer
  import serializer_pkg::*;
#(
  parameter int DATA_SIZE = DATA_SIZE_DEFAULT
) (
  input  logic         iClk,
  input  logic         iRst,
  serializer_if.slave  bus
);

  localparam int CW = cnt_width(DATA_SIZE);

  state_e               state_q;
  logic [DATA_SIZE-1:0] shreg_q;
  logic                 serial_q;
  logic                 load_flag_q;
  logic [CW-1:0]        cnt_q;
  logic                 done_q;

  // Combinational next values for the datapath, applied by the FSM below.
  logic [DATA_SIZE-1:0] shreg_d;
  logic [CW-1:0]        cnt_d;
  logic                 last_bit_d;

  assign shreg_d    = {shreg_q[DATA_SIZE-2:0], 1'b0};
  assign cnt_d      = cnt_q + CW'(1);
  // True while the bit about to be shifted is the final one of the frame.
  assign last_bit_d = (cnt_q == CW'(DATA_SIZE - 1));

  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) begin
      state_q     <= ST_IDLE;
      shreg_q     <= '0;
      serial_q    <= 1'b0;
      load_flag_q <= 1'b0;
      cnt_q       <= '0;
      done_q      <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          serial_q    <= 1'b0;
          load_flag_q <= 1'b0;
          done_q      <= 1'b0;
          if (bus.iValid) begin
            shreg_q <= bus.iData;
            cnt_q   <= '0;
            state_q <= ST_SHIFT;
          end
        end

        ST_SHIFT: begin
          done_q <= 1'b0;
          if (bus.iEn) begin
            serial_q    <= shreg_q[DATA_SIZE-1];
            shreg_q     <= shreg_d;
            load_flag_q <= 1'b1;
            cnt_q       <= cnt_d;
            if (last_bit_d) begin
              state_q <= ST_DONE;
              // Registered so oDone is high exactly while in ST_DONE.
              done_q  <= 1'b1;
            end
          end else begin
            // Stall: gap cycle, datapath and state hold.
            serial_q    <= 1'b0;
            load_flag_q <= 1'b0;
          end
        end

        ST_DONE: begin
          // Counter deliberately keeps DATA_SIZE until the next capture.
          serial_q    <= 1'b0;
          load_flag_q <= 1'b0;
          done_q      <= 1'b0;
          state_q     <= ST_IDLE;
        end

        default: begin
          serial_q    <= 1'b0;
          load_flag_q <= 1'b0;
          done_q      <= 1'b0;
          state_q     <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.oReady       = (state_q == ST_IDLE);
  assign bus.oBusy        = (state_q == ST_SHIFT) || (state_q == ST_DONE);
  assign bus.oSerial_out  = serial_q;
  assign bus.oLoad_flag   = load_flag_q;
  assign bus.oBit_counter = cnt_q;
  assign bus.oDone        = done_q;

endmodule : serializer
